// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner.
//   state_e        : scanner FSM states (scan columns, confirm a press, wait for release)
//   HEX_LEGEND     : printed legend of the keypad, 4 bits per key, indexed by {row, col}
//   lowest_low_row : index of the lowest-numbered active-low row in a row vector
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan    = 2'd0,
        StConfirm = 2'd1,
        StHeld    = 2'd2
    } state_e;

    // Nibble i holds the legend of key {row, col} == i. Layout, rows 0..3:
    //   1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
    localparam logic [63:0] HEX_LEGEND = 64'hDEF0_C987_B654_A321;

    // Lowest row index wins when several rows are pulled low at once.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_n[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync2.sv
// keypad_sync2: 4-bit two-flop synchronizer for the asynchronous keypad row lines.
// Resets to 4'b1111 (all rows released, since rows are active-low with pull-ups).
//   clk   : system clock
//   reset : asynchronous, active-high
//   d     : asynchronous input bits
//   q     : synchronized output bits
module keypad_sync2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and single-event-per-press output.
// One column is driven low at a time; rows are sampled once per 2^TICK_N clocks.
// A press must be seen on DEB_CNT consecutive ticks to be accepted, and a release must be
// seen on DEB_CNT consecutive ticks before scanning resumes.
//
// Optional build macro: KEYPAD_HEX_MAP_EN
//   defined     : key_code is the printed legend value of the key
//   not defined : key_code = {row[1:0], col[1:0]}
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   row_n     in   [3:0] keypad rows, active-low, asynchronous to clk
//   col_n     out  [3:0] column drive, active-low, exactly one bit low
//   key_code  out  [3:0] code of the last accepted key (held until the next one)
//   key_valid out  one-cycle pulse coincident with a key_code update
//   key_down  out  high while the accepted key is held (debounced)
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned TICK_N  = 17,
    parameter int unsigned DEB_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam logic [3:0]        DebCnt   = 4'(DEB_CNT);
    localparam logic [TICK_N-1:0] PrescOne = {{(TICK_N - 1){1'b0}}, 1'b1};

    logic [3:0] rows_s;

    keypad_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (rows_s)
    );

    // Prescaler: free-running, tick in the all-ones cycle.
    logic [TICK_N-1:0] presc_q, presc_d;
    logic              tick;

    assign presc_d = presc_q + PrescOne;
    assign tick    = &presc_q;

    state_e     state_q, state_d;
    logic [1:0] col_q, col_d;
    logic [1:0] row_q, row_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       down_q, down_d;

    logic       any_low;
    logic [1:0] sel_row;
    logic       latched_low;
    logic [3:0] cnt_inc;
    logic [3:0] code_sel;

    assign any_low     = ~&rows_s;
    assign sel_row     = lowest_low_row(rows_s);
    assign latched_low = ~rows_s[row_q];
    assign cnt_inc     = cnt_q + 4'd1;

`ifdef KEYPAD_HEX_MAP_EN
    assign code_sel = HEX_LEGEND[{row_q, col_q, 2'b00} +: 4];
`else
    assign code_sel = {row_q, col_q};
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        down_d  = down_q;

        case (state_q)
            StScan: begin
                if (tick) begin
                    if (!any_low) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        row_d   = sel_row;
                        cnt_d   = 4'd1;
                        state_d = StConfirm;
                    end
                end
            end

            StConfirm: begin
                if (tick) begin
                    // Continue only while the latched row is still the selected one;
                    // a lower row appearing counts as a different key and aborts.
                    if (any_low && (sel_row == row_q)) begin
                        if (cnt_inc == DebCnt) begin
                            code_d  = code_sel;
                            valid_d = 1'b1;
                            down_d  = 1'b1;
                            cnt_d   = 4'd0;
                            state_d = StHeld;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        col_d   = col_q + 2'd1;
                        state_d = StScan;
                    end
                end
            end

            StHeld: begin
                if (tick) begin
                    // Only the latched row in the held column matters; other keys are ignored.
                    if (!latched_low) begin
                        if (cnt_inc == DebCnt) begin
                            down_d  = 1'b0;
                            cnt_d   = 4'd0;
                            col_d   = col_q + 2'd1;
                            state_d = StScan;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
            end

            default: begin
                // Unreachable encoding: recover at once rather than waiting for a tick.
                state_d = StScan;
                cnt_d   = 4'd0;
                down_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            state_q <= StScan;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            cnt_q   <= 4'd0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            down_q  <= down_d;
        end
    end

    assign col_n     = ~(4'b0001 << col_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_down  = down_q;

endmodule
